// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types for the unified-memory I/D port arbiter.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} arb_owner_e;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: data port wins unless fetch has lost MAX_WAIT arbitrations in a row.
module arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int WW       = 3
) (
    input  logic          i_ireq,
    input  logic          i_dreq,
    input  logic [WW-1:0] i_wait_cnt,
    output arb_owner_e    o_winner
);
    logic w_starve;

    assign w_starve = i_ireq && (i_wait_cnt == WW'(MAX_WAIT));
    assign o_winner = (i_dreq && !w_starve) ? OWN_D : i_ireq ? OWN_I : OWN_NONE;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between fetch (I) and data (D) ports.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LAT      = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_f,
    output logic        stall_m
);
    localparam int CW = cnt_width(LAT);
    localparam int WW = cnt_width(MAX_WAIT);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    arb_owner_e    r_owner;
    arb_owner_e    w_winner;
    logic          r_we;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_wait_cnt;
    logic          w_grant;
    logic          w_grant_d;
    logic          w_cnt_done;

    arb_pick #(.MAX_WAIT(MAX_WAIT), .WW(WW)) u_pick (
        .i_ireq     (i_req),
        .i_dreq     (d_req),
        .i_wait_cnt (r_wait_cnt),
        .o_winner   (w_winner)
    );

    assign w_grant    = (r_state == IDLE) && (w_winner != OWN_NONE);
    assign w_grant_d  = w_winner == OWN_D;
    assign w_cnt_done = r_cnt == CW'(LAT);
    assign stall_f    = i_req & ~i_ready;
    assign stall_m    = d_req & ~d_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_grant ? ISSUE : IDLE;
            ISSUE:   w_state_nxt = r_we ? DONE : WAIT;
            WAIT:    w_state_nxt = w_cnt_done ? DONE : WAIT;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Strobes default low each cycle so mem_en and ready pulses last exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= OWN_NONE;
            r_we       <= 1'b0;
            r_cnt      <= '0;
            r_wait_cnt <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner   <= w_winner;
                        r_we      <= w_grant_d && d_we;
                        mem_en    <= 1'b1;
                        mem_we    <= w_grant_d && d_we;
                        mem_addr  <= w_grant_d ? d_addr : i_addr;
                        mem_wdata <= w_grant_d ? d_wdata : mem_wdata;
                        if (!w_grant_d)
                            r_wait_cnt <= '0;
                        else if (i_req && r_wait_cnt != WW'(MAX_WAIT))
                            r_wait_cnt <= r_wait_cnt + WW'(1);
                    end
                end
                ISSUE: begin
                    r_cnt   <= CW'(1);
                    d_ready <= r_we;
                end
                WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_cnt_done) begin
                        if (r_owner == OWN_I) begin
                            i_rdata <= mem_rdata;
                            i_ready <= 1'b1;
                        end else begin
                            d_rdata <= mem_rdata;
                            d_ready <= 1'b1;
                        end
                    end
                end
                default: r_owner <= OWN_NONE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the I/D arbiter against a 2-cycle-latency memory model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_f;
    logic        stall_m;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.LAT(2), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_f   (stall_f),
        .stall_m   (stall_m)
    );

    always #5 clk = ~clk;

    // Two-stage read pipeline: data is valid only in the cycle LAT=2 after the mem_en cycle.
    logic [31:0] mem [0:63];
    logic [31:0] rd1, rd2;
    logic        rv1, rv2;
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'h1000_0000 | k;
            mem[2] <= 32'hE3A0_8001;
            mem[3] <= 32'h1111_2222;
            mem[4] <= 32'h3333_4444;
            rv1 <= 1'b0;
            rv2 <= 1'b0;
        end else begin
            if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            rv1 <= mem_en && !mem_we;
            rd1 <= mem[mem_addr[7:2]];
            rv2 <= rv1;
            rd2 <= rd1;
        end
    end
    assign mem_rdata = rv2 ? rd2 : 32'hBAD0_BAD0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        // 1: reset with random requests
        for (int c = 0; c < 2; c++) begin
            i_req = 1'($urandom);
            d_req = 1'($urandom);
            d_we  = 1'($urandom);
            i_addr = $urandom;
            d_addr = $urandom;
            step();
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_rdy", {30'd0, i_ready, d_ready}, 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        rst   = 1'b0;
        step();
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        chk("rst_mem_en_post", 32'(mem_en), 0);

        // 2: lone fetch of 0x08
        i_addr = 32'h08;
        i_req  = 1'b1;
        #1;
        chk("f_stall_T", 32'(stall_f), 1);
        step();
        chk("f_mem_en_T1", {30'd0, mem_en, mem_we}, 32'h2);
        chk("f_mem_addr_T1", mem_addr, 32'h08);
        step();
        chk("f_mem_en_T2", 32'(mem_en), 0);
        chk("f_stall_T2", 32'(stall_f), 1);
        step();
        chk("f_ready_T3", 32'(i_ready), 0);
        chk("f_stall_T3", 32'(stall_f), 1);
        step();
        chk("f_ready_T4", 32'(i_ready), 1);
        chk("f_rdata_T4", i_rdata, 32'hE3A0_8001);
        chk("f_stall_T4", 32'(stall_f), 0);
        chk("f_d_ready_T4", 32'(d_ready), 0);
        i_req = 1'b0;
        step();
        chk("f_ready_T5", 32'(i_ready), 0);
        chk("f_rdata_hold", i_rdata, 32'hE3A0_8001);

        // 3: store then load of 0x20
        d_addr  = 32'h20;
        d_wdata = 32'hDEAD_BEEF;
        d_we    = 1'b1;
        d_req   = 1'b1;
        step();
        chk("st_mem_T1", {30'd0, mem_en, mem_we}, 32'h3);
        chk("st_addr_T1", mem_addr, 32'h20);
        chk("st_wdata_T1", mem_wdata, 32'hDEAD_BEEF);
        step();
        chk("st_ready_T2", 32'(d_ready), 1);
        chk("st_mem_we_T2", 32'(mem_we), 0);
        chk("st_stall_m_T2", 32'(stall_m), 0);
        d_req = 1'b0;
        step();
        d_we  = 1'b0;
        d_req = 1'b1;
        repeat (3) step();
        chk("ld_ready_T3", 32'(d_ready), 0);
        step();
        chk("ld_ready_T4", 32'(d_ready), 1);
        chk("ld_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("ld_i_ready", 32'(i_ready), 0);
        d_req = 1'b0;
        step();

        // 4: simultaneous I (0x0C) and D load (0x20): D first
        i_addr = 32'h0C;
        i_req  = 1'b1;
        d_addr = 32'h20;
        d_req  = 1'b1;
        step();
        chk("both_mem_addr_T1", mem_addr, 32'h20);
        repeat (3) step();
        chk("both_d_ready_T4", 32'(d_ready), 1);
        chk("both_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("both_i_ready_T4", 32'(i_ready), 0);
        chk("both_stalls_T4", {30'd0, stall_f, stall_m}, 32'h2);
        d_req = 1'b0;
        step();
        step();
        chk("both_mem_en_T6", 32'(mem_en), 1);
        chk("both_mem_addr_T6", mem_addr, 32'h0C);
        repeat (2) step();
        chk("both_i_ready_T8", 32'(i_ready), 0);
        step();
        chk("both_i_ready_T9", 32'(i_ready), 1);
        chk("both_i_rdata", i_rdata, 32'h1111_2222);
        chk("both_wait_cnt", 32'(dut.r_wait_cnt), 0);
        i_req = 1'b0;
        step();

        // 5: starvation bound: D wins 4 rounds, I takes round 5
        i_addr = 32'h08;
        i_req  = 1'b1;
        d_addr = 32'h10;
        d_req  = 1'b1;
        for (int r = 0; r < 4; r++) begin
            repeat (4) step();
            chk("starve_d_ready", 32'(d_ready), 1);
            chk("starve_i_ready", 32'(i_ready), 0);
            chk("starve_wait_cnt", 32'(dut.r_wait_cnt), 32'(r + 1));
            chk("starve_d_rdata", d_rdata, 32'h3333_4444);
            step();
        end
        repeat (4) step();
        chk("starve_i_win", 32'(i_ready), 1);
        chk("starve_d_idle", 32'(d_ready), 0);
        chk("starve_i_rdata", i_rdata, 32'hE3A0_8001);
        chk("starve_wait_clr", 32'(dut.r_wait_cnt), 0);
        i_req = 1'b0;
        d_req = 1'b0;
        step();

        // 6: reset during WAIT abandons the I read
        i_addr = 32'h0C;
        i_req  = 1'b1;
        step();
        step();
        chk("rw_state_wait", 32'(dut.r_state), 32'(WAIT));
        chk("rw_cnt", 32'(dut.r_cnt), 1);
        rst = 1'b1;
        step();
        rst   = 1'b0;
        i_req = 1'b0;
        chk("rw_state_idle", 32'(dut.r_state), 32'(IDLE));
        chk("rw_i_ready", 32'(i_ready), 0);
        chk("rw_i_rdata", i_rdata, 0);
        step();
        chk("rw_i_ready_after", 32'(i_ready), 0);
        chk("rw_i_rdata_after", i_rdata, 0);
        i_req = 1'b1;
        step();
        chk("rw_new_mem_en", 32'(mem_en), 1);
        repeat (3) step();
        chk("rw_new_ready", 32'(i_ready), 1);
        chk("rw_new_rdata", i_rdata, 32'h1111_2222);
        i_req = 1'b0;
        step();
        chk("rw_new_ready_end", 32'(i_ready), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
